// File: rtl/apb_gpio_arbiter.sv
// Round-robin APB master: shares one APB GPIO slave among NREQ requesters,
// one SETUP+ACCESS transfer per grant, ACCESS bounded by a PREADY timeout.
module apb_gpio_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*32-1:0]     req_addr,
  input  logic [NREQ*32-1:0]     req_wdata,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PADDR,
  output logic [31:0]            PWDATA,
  input  logic                   PREADY,
  input  logic [31:0]            PRDATA
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NREQ-1:0]    req_ack_d, rsp_valid_d;
  logic [31:0]        rsp_rdata_d, paddr_d, pwdata_d;
  logic               rsp_err_d, busy_d, psel_d, penable_d, pwrite_d;

  logic [PTR_W-1:0]   grant, hi_idx, lo_idx;
  logic               hi_found, lo_found;
  logic               sel_write;
  logic [31:0]        sel_addr, sel_wdata;

  // Round-robin pick: lowest requester above ptr, else lowest at/below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (PTR_W'(i) > ptr) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = PTR_W'(i);
        end
      end
    end
    grant     = hi_found ? hi_idx : lo_idx;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (PTR_W'(i) == grant) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cnt_d       = cnt;
    req_ack_d   = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    case (state)
      IDLE: begin
        if (hi_found || lo_found) begin
          state_d          = SETUP;
          ptr_d            = grant;
          req_ack_d[grant] = 1'b1;
          psel_d           = 1'b1;
          penable_d        = 1'b0;
          pwrite_d         = sel_write;
          paddr_d          = sel_addr;
          pwdata_d         = sel_write ? sel_wdata : 32'h0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d        = RESP;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          rsp_valid_d[ptr] = 1'b1;
          rsp_rdata_d    = PWRITE ? 32'h0 : PRDATA;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d        = RESP;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          rsp_valid_d[ptr] = 1'b1;
          rsp_err_d      = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and all registered outputs.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ptr       <= PTR_W'(NREQ - 1);
      cnt       <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      req_ack   <= req_ack_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
    end
  end

endmodule
